mult_accum_pipe: RTL and testbench

//   Parametrised, pipelined multiply-accumulate unit; next generation of the 16x16 DSP MAC.

---
 rtl/mult_accum_pipe_pkg.sv | 22 ++
 rtl/mult_accum_pipe_if.sv | 25 ++
 rtl/mult_accum_pipe_s2.sv | 32 +++
 rtl/mult_accum_pipe.sv | 112 +++++++++++
 tb/tb_mult_accum_pipe.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/mult_accum_pipe_pkg.sv
// Shared op encodings, pipeline latency and per-stage control word for the MAC pipeline.
package mult_accum_pkg;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MAC  = 2'b01;
  localparam logic [1:0] OP_MSC  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  localparam int MAC_LATENCY = 3;

  // Control that travels alongside the operands so each op keeps its own mode.
  typedef struct packed {
    logic       valid;
    logic [1:0] op;
    logic       is_signed;
  } stage_ctl_t;

  function automatic logic is_accumulating(input logic [1:0] op);
    return (op == OP_MAC) || (op == OP_MSC);
  endfunction

endpackage

// File: rtl/mult_accum_pipe_if.sv
// Op/result bus of the MAC pipeline; master issues ops, slave (the MAC) returns results.
interface mult_accum_pipe_if #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 40
);
  logic             in_valid;
  logic [IN_W-1:0]  in_a;
  logic [IN_W-1:0]  in_b;
  logic [1:0]       in_op;
  logic             in_signed;
  logic             clear_accum;
  logic             out_valid;
  logic [ACC_W-1:0] out_acc;
  logic             overflow;

  modport master (
    output in_valid, in_a, in_b, in_op, in_signed, clear_accum,
    input  out_valid, out_acc, overflow
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_signed, clear_accum,
    output out_valid, out_acc, overflow
  );
endinterface

// File: rtl/mult_accum_pipe_s2.sv
// S1->S2 stage: registered IN_W x IN_W multiply (signed or unsigned) or {a,b} pass-through.
module mult_pipe_s2 #(
  parameter int IN_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [IN_W-1:0]   a,
  input  logic [IN_W-1:0]   b,
  input  logic              is_signed,
  input  logic              pass,
  output logic [2*IN_W-1:0] prod
);
  localparam int PW = 2 * IN_W;

  logic [PW-1:0] a_ext, b_ext, prod_next;

  // Extending both operands to PW bits makes the low PW bits of one product
  // correct for either signedness.
  always_comb begin
    a_ext     = is_signed ? {{IN_W{a[IN_W-1]}}, a} : {{IN_W{1'b0}}, a};
    b_ext     = is_signed ? {{IN_W{b[IN_W-1]}}, b} : {{IN_W{1'b0}}, b};
    prod_next = pass ? {a, b} : a_ext * b_ext;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prod <= '0;
    end else begin
      prod <= prod_next;
    end
  end
endmodule

// File: rtl/mult_accum_pipe.sv
// Three-stage pipelined multiply-accumulate with sticky overflow.
// Define MULT_ACCUM_SAT_EN to clamp the accumulator on overflow instead of wrapping.
module mult_accum_pipe
  import mult_accum_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int ACC_W = 40
) (
  input logic              clk,
  input logic              reset_n,
  mult_accum_pipe_if.slave bus
);
  localparam int PW = 2 * IN_W;

  if (ACC_W < PW) begin : g_width_check
    $error("mult_accum_pipe: ACC_W must be at least 2*IN_W");
  end

  logic [IN_W-1:0]  s1_a_reg, s1_b_reg;
  stage_ctl_t       s1_ctl_reg, s2_ctl_reg;
  logic [PW-1:0]    s2_prod;
  logic [ACC_W-1:0] acc_reg, acc_next, ext, res;
  logic             ovf_reg, ovf_hit, out_valid_reg;
  logic [ACC_W:0]   sum_w, diff_w;

  mult_pipe_s2 #(.IN_W(IN_W)) u_mult (
    .clk       (clk),
    .reset_n   (reset_n),
    .a         (s1_a_reg),
    .b         (s1_b_reg),
    .is_signed (s1_ctl_reg.is_signed),
    .pass      (s1_ctl_reg.op == OP_PASS),
    .prod      (s2_prod)
  );

  genvar gi;
  for (gi = 0; gi < ACC_W; gi++) begin : g_ext
    if (gi < PW) begin : g_low
      assign ext[gi] = s2_prod[gi];
    end else begin : g_fill
      assign ext[gi] = s2_ctl_reg.is_signed & s2_prod[PW-1];
    end
  end

  always_comb begin
    sum_w   = {1'b0, acc_reg} + {1'b0, ext};
    diff_w  = {1'b0, acc_reg} - {1'b0, ext};
    res     = ext;
    ovf_hit = 1'b0;
    case (s2_ctl_reg.op)
      OP_MAC: begin
        res     = sum_w[ACC_W-1:0];
        ovf_hit = s2_ctl_reg.is_signed
                ? (acc_reg[ACC_W-1] == ext[ACC_W-1]) && (res[ACC_W-1] != acc_reg[ACC_W-1])
                : sum_w[ACC_W];
      end
      OP_MSC: begin
        res     = diff_w[ACC_W-1:0];
        ovf_hit = s2_ctl_reg.is_signed
                ? (acc_reg[ACC_W-1] != ext[ACC_W-1]) && (res[ACC_W-1] != acc_reg[ACC_W-1])
                : diff_w[ACC_W];
      end
      default: res = ext;
    endcase
    acc_next = res;
`ifdef MULT_ACCUM_SAT_EN
    // A signed overflow always runs away from the sign the accumulator had.
    if (ovf_hit && is_accumulating(s2_ctl_reg.op)) begin
      if (s2_ctl_reg.is_signed) begin
        acc_next = acc_reg[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        acc_next = (s2_ctl_reg.op == OP_MAC) ? {ACC_W{1'b1}} : {ACC_W{1'b0}};
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_a_reg      <= '0;
      s1_b_reg      <= '0;
      s1_ctl_reg    <= '0;
      s2_ctl_reg    <= '0;
      acc_reg       <= '0;
      ovf_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      s1_a_reg             <= bus.in_a;
      s1_b_reg             <= bus.in_b;
      s1_ctl_reg.valid     <= bus.in_valid;
      s1_ctl_reg.op        <= bus.in_op;
      s1_ctl_reg.is_signed <= bus.in_signed;
      s2_ctl_reg           <= s1_ctl_reg;
      // Clear wins over the op reaching S3; ops still in S1/S2 carry on from zero.
      if (bus.clear_accum) begin
        acc_reg       <= '0;
        ovf_reg       <= 1'b0;
        out_valid_reg <= 1'b0;
      end else if (s2_ctl_reg.valid) begin
        acc_reg       <= acc_next;
        ovf_reg       <= ovf_reg | ovf_hit;
        out_valid_reg <= 1'b1;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_acc   = acc_reg;
  assign bus.overflow  = ovf_reg;
endmodule

// File: tb/tb_mult_accum_pipe.sv
// Self-checking bench for mult_accum_pipe: directed cases plus random ops against an arithmetic model.
module tb_mult_accum_pipe;
  import mult_accum_pkg::*;

  localparam int IN_W  = 16;
  localparam int ACC_W = 40;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mult_accum_pipe_if #(.IN_W(IN_W), .ACC_W(ACC_W)) bus ();

  mult_accum_pipe #(.IN_W(IN_W), .ACC_W(ACC_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    bit          v;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    bit          s;
  } op_t;

  op_t              pend[$];
  logic [ACC_W-1:0] m_acc;
  bit               m_ovf;
  bit               m_vld;
  int               total = 0;
  int               bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: each op lands in order, MAC_LATENCY edges after issue, as exact integer arithmetic.
  task automatic model_edge(input bit clr);
    op_t    e;
    longint acc_v, ext_v, res, lo, hi;
    m_vld = 1'b0;
    if (pend.size() < MAC_LATENCY) begin
      if (clr) begin m_acc = '0; m_ovf = 1'b0; end
      return;
    end
    e = pend.pop_front();
    if (clr) begin m_acc = '0; m_ovf = 1'b0; return; end
    if (!e.v) return;
    if (e.op == OP_PASS)
      ext_v = e.s ? longint'($signed({e.a, e.b})) : longint'({e.a, e.b});
    else
      ext_v = e.s ? longint'($signed(e.a)) * longint'($signed(e.b)) : longint'(e.a) * longint'(e.b);
    acc_v = e.s ? longint'($signed(m_acc)) : longint'(m_acc);
    lo = e.s ? -(longint'(1) << (ACC_W - 1)) : 0;
    hi = e.s ? (longint'(1) << (ACC_W - 1)) - 1 : (longint'(1) << ACC_W) - 1;
    case (e.op)
      OP_MAC:  res = acc_v + ext_v;
      OP_MSC:  res = acc_v - ext_v;
      default: res = ext_v;
    endcase
    if (res < lo || res > hi) begin
      m_ovf = 1'b1;
`ifdef MULT_ACCUM_SAT_EN
      res = (res < lo) ? lo : hi;
`endif
    end
    m_acc = res[ACC_W-1:0];
    m_vld = 1'b1;
  endtask

  task automatic step(input bit v, input logic [15:0] a, input logic [15:0] b,
                      input logic [1:0] op, input bit s, input bit clr);
    op_t e;
    bus.in_valid    = v;
    bus.in_a        = a;
    bus.in_b        = b;
    bus.in_op       = op;
    bus.in_signed   = s;
    bus.clear_accum = clr;
    e.v = v; e.a = a; e.b = b; e.op = op; e.s = s;
    pend.push_back(e);
    @(posedge clk);
    #1;
    model_edge(clr);
    $display("op v=%0d op=%0d s=%0d a=%h b=%h clr=%0d -> out_valid=%0d acc=%h ovf=%0d",
             v, op, s, a, b, clr, bus.out_valid, bus.out_acc, bus.overflow);
    check("out_valid", 64'(bus.out_valid), 64'(m_vld));
    check("out_acc", 64'(bus.out_acc), 64'(m_acc));
    check("overflow", 64'(bus.overflow), 64'(m_ovf));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, OP_MUL, 1'b0, 1'b0);
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_a        = '0;
    bus.in_b        = '0;
    bus.in_op       = OP_MUL;
    bus.in_signed   = 1'b0;
    bus.clear_accum = 1'b0;
    m_acc = '0; m_ovf = 1'b0; m_vld = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_acc", 64'(bus.out_acc), 64'd0);
    check("rst_ovf", 64'(bus.overflow), 64'd0);
    reset_n = 1'b1;

    // 1: signed MUL 3 * -4
    step(1'b1, 16'd3, 16'hFFFC, OP_MUL, 1'b1, 1'b0);
    idle(1);
    check("t1_early_valid", 64'(bus.out_valid), 64'd0);
    idle(1);
    check("t1_valid", 64'(bus.out_valid), 64'd1);
    check("t1_acc", 64'(bus.out_acc), 64'hFF_FFFF_FFF4);

    // 2: four back-to-back MACs after clear
    step(1'b0, 16'h0, 16'h0, OP_MUL, 1'b0, 1'b1);
    step(1'b1, 16'd1000, 16'd1000, OP_MAC, 1'b0, 1'b0);
    step(1'b1, 16'd1000, 16'd1000, OP_MAC, 1'b0, 1'b0);
    step(1'b1, 16'd1000, 16'd1000, OP_MAC, 1'b0, 1'b0);
    check("t2_acc1", 64'(bus.out_acc), 64'd1000000);
    step(1'b1, 16'd1000, 16'd1000, OP_MAC, 1'b0, 1'b0);
    check("t2_acc2", 64'(bus.out_acc), 64'd2000000);
    idle(1);
    check("t2_acc3", 64'(bus.out_acc), 64'd3000000);
    idle(1);
    check("t2_acc4", 64'(bus.out_acc), 64'd4000000);
    idle(1);

    // 3: unsigned MSC below zero
    step(1'b0, 16'h0, 16'h0, OP_MUL, 1'b0, 1'b1);
    step(1'b1, 16'd1, 16'd1, OP_MSC, 1'b0, 1'b0);
    idle(2);
`ifdef MULT_ACCUM_SAT_EN
    check("t3_acc", 64'(bus.out_acc), 64'd0);
`else
    check("t3_acc", 64'(bus.out_acc), 64'hFF_FFFF_FFFF);
`endif
    check("t3_ovf", 64'(bus.overflow), 64'd1);

    // 4: PASS loads {a,b}; overflow stays sticky
    step(1'b1, 16'h1234, 16'h5678, OP_PASS, 1'b0, 1'b0);
    idle(2);
    check("t4_acc", 64'(bus.out_acc), 64'h1234_5678);
    check("t4_ovf", 64'(bus.overflow), 64'd1);

    // 5: clear coincides with a MAC in S3; next MAC accumulates onto zero
    step(1'b1, 16'd2, 16'd3, OP_MAC, 1'b0, 1'b0);
    step(1'b1, 16'd5, 16'd7, OP_MAC, 1'b0, 1'b0);
    step(1'b0, 16'h0, 16'h0, OP_MUL, 1'b0, 1'b1);
    check("t5_clr_valid", 64'(bus.out_valid), 64'd0);
    check("t5_clr_acc", 64'(bus.out_acc), 64'd0);
    check("t5_clr_ovf", 64'(bus.overflow), 64'd0);
    idle(1);
    check("t5_acc", 64'(bus.out_acc), 64'd35);
    idle(1);

    // 6: reset mid-stream with two ops in flight
    step(1'b1, 16'd9, 16'd9, OP_MAC, 1'b0, 1'b0);
    step(1'b1, 16'd4, 16'd4, OP_MAC, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("t6_valid", 64'(bus.out_valid), 64'd0);
    check("t6_acc", 64'(bus.out_acc), 64'd0);
    check("t6_ovf", 64'(bus.overflow), 64'd0);
    pend.delete();
    m_acc = '0; m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    idle(3);

    // Unsigned wrap/clip on MAC, then signed positive and negative limits
    step(1'b0, 16'h0, 16'h0, OP_MUL, 1'b0, 1'b1);
    for (int i = 0; i < 260; i++) step(1'b1, 16'hFFFF, 16'hFFFF, OP_MAC, 1'b0, 1'b0);
    idle(3);
    check("umac_ovf", 64'(bus.overflow), 64'd1);
    step(1'b0, 16'h0, 16'h0, OP_MUL, 1'b0, 1'b1);
    for (int i = 0; i < 520; i++) step(1'b1, 16'h8000, 16'h8000, OP_MAC, 1'b1, 1'b0);
    idle(3);
    check("smac_ovf", 64'(bus.overflow), 64'd1);
    step(1'b0, 16'h0, 16'h0, OP_MUL, 1'b0, 1'b1);
    for (int i = 0; i < 520; i++) step(1'b1, 16'h8000, 16'h8000, OP_MSC, 1'b1, 1'b0);
    idle(3);
    check("smsc_ovf", 64'(bus.overflow), 64'd1);

    // Random mixed ops, modes, bubbles and clears
    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
           2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 15) == 0));
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
